// File: rtl/ext_pipe.sv
// Immediate-extension stage feeding a small power-of-two result FIFO.
// Optional macro EXT_PIPE_BRANCH_EN enables the branch-offset mode (in_op=3).
module ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IMM_W-1:0]             in_imm,
    input  logic [2:0]                   in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_err,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    // Result word layout: {err, data}
    function automatic logic [OUT_W:0] ext_calc(input logic [IMM_W-1:0] imm,
                                                input logic [2:0]       op);
        logic [OUT_W-1:0] sext_v;
        logic [OUT_W:0]   res_v;
        sext_v = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
        case (op)
            3'd0:    res_v = {1'b0, sext_v};
            3'd1:    res_v = {1'b0, {(OUT_W-IMM_W){1'b0}}, imm};
            3'd2:    res_v = {1'b0, imm, {(OUT_W-IMM_W){1'b0}}};
`ifdef EXT_PIPE_BRANCH_EN
            3'd3:    res_v = {1'b0, sext_v[OUT_W-3:0], 2'b00};
`endif
            default: res_v = {1'b1, {OUT_W{1'b0}}};
        endcase
        return res_v;
    endfunction

    logic [OUT_W:0]   mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             ready_en_r;
    logic             push_s;
    logic             pop_s;
    logic [OUT_W:0]   push_res_s;
    logic [OUT_W:0]   head_s;

    assign level     = level_r;
    assign out_valid = (level_r != LVL_W'(0));
    // ready_en_r keeps in_ready low until the first edge after reset release
    assign in_ready  = ready_en_r && (level_r != LVL_W'(DEPTH));
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Compute the extended result for the incoming immediate
    always_comb begin
        push_res_s = ext_calc(in_imm, in_op);
    end

    // Head presentation; outputs forced to zero when nothing is buffered
    always_comb begin
        head_s = '0;
        if (out_valid) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign out_data = head_s[OUT_W-1:0];
    assign out_err  = head_s[OUT_W];

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_res_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe (IMM_W=16, OUT_W=32, DEPTH=2).
module tb_ext_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [1:0]  level;

    int n_cmp;
    int n_bad;

    ext_pipe #(.IMM_W(16), .OUT_W(32), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] imm);
        in_valid = v;
        in_op    = op;
        in_imm   = imm;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0000);

        // Reset asserted, no clock edge yet
        #3;
        check("rst_level",     {30'd0, level},     32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_out_err",   {31'd0, out_err},   32'd0);

        step();
        step();
        reset = 1'b0;
        step();
        check("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Sign extension, immediate pop
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 16'h8001);
        step();
        drive(1'b0, 3'd0, 16'h0000);
        check("op0_valid", {31'd0, out_valid}, 32'd1);
        check("op0_data",  out_data,           32'hFFFF8001);
        check("op0_err",   {31'd0, out_err},   32'd0);
        check("op0_level", {30'd0, level},     32'd1);
        step();
        check("op0_level_after", {30'd0, level},     32'd0);
        check("op0_valid_after", {31'd0, out_valid}, 32'd0);
        check("op0_data_after",  out_data,           32'd0);

        // Zero extension then upper placement, buffered
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h8001);
        step();
        drive(1'b1, 3'd2, 16'h1234);
        step();
        drive(1'b0, 3'd0, 16'h0000);
        check("op12_level",    {30'd0, level},    32'd2);
        check("op12_in_ready", {31'd0, in_ready}, 32'd0);
        check("op1_data",      out_data,          32'h00008001);
        check("op1_err",       {31'd0, out_err},  32'd0);
        out_ready = 1'b1;
        step();
        check("op2_data",  out_data,          32'h12340000);
        check("op2_err",   {31'd0, out_err},  32'd0);
        check("op2_level", {30'd0, level},    32'd1);
        step();
        check("op12_drain", {30'd0, level}, 32'd0);

        // Branch offset and illegal op
        drive(1'b1, 3'd3, 16'hFFFF);
        step();
        drive(1'b0, 3'd0, 16'h0000);
`ifdef EXT_PIPE_BRANCH_EN
        check("op3_data", out_data,         32'hFFFFFFFC);
        check("op3_err",  {31'd0, out_err}, 32'd0);
`else
        check("op3_data", out_data,         32'h00000000);
        check("op3_err",  {31'd0, out_err}, 32'd1);
`endif
        step();
        drive(1'b1, 3'd5, 16'hABCD);
        step();
        drive(1'b0, 3'd0, 16'h0000);
        check("op5_valid", {31'd0, out_valid}, 32'd1);
        check("op5_data",  out_data,           32'h00000000);
        check("op5_err",   {31'd0, out_err},   32'd1);
        step();
        drive(1'b1, 3'd0, 16'h7FFF);
        step();
        drive(1'b0, 3'd0, 16'h0000);
        check("op0_pos_data", out_data, 32'h00007FFF);
        step();

        // Backpressure: A, B accepted, C held until space frees
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h000A);
        step();
        drive(1'b1, 3'd1, 16'h000B);
        step();
        drive(1'b1, 3'd1, 16'h000C);
        step();
        check("bp_level",    {30'd0, level},    32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_head_A",   out_data,          32'h0000000A);
        out_ready = 1'b1;
        step();
        check("bp_pop_A_level", {30'd0, level},    32'd1);
        check("bp_head_B",      out_data,          32'h0000000B);
        check("bp_in_ready_1",  {31'd0, in_ready}, 32'd1);
        step();
        check("bp_push_C_level", {30'd0, level}, 32'd1);
        check("bp_head_C",       out_data,       32'h0000000C);
        drive(1'b0, 3'd0, 16'h0000);
        step();
        check("bp_drain", {30'd0, level}, 32'd0);

        // Steady push+pop at level 1, pointers wrap
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h0010);
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 3'd1, 16'(16'h0010 + i));
            step();
            check("ss_level", {30'd0, level}, 32'd1);
            check("ss_head",  out_data,       32'h00000010 + 32'(i));
        end
        drive(1'b0, 3'd0, 16'h0000);
        step();
        check("ss_drain", {30'd0, level}, 32'd0);

        // Mid-cycle reset with a full buffer
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h00E1);
        step();
        drive(1'b1, 3'd1, 16'h00E2);
        step();
        drive(1'b0, 3'd0, 16'h0000);
        check("mr_level_pre", {30'd0, level}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mr_level",     {30'd0, level},     32'd0);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_in_ready",  {31'd0, in_ready},  32'd0);
        check("mr_out_data",  out_data,           32'd0);
        #1;
        reset = 1'b0;
        step();
        check("mr_in_ready_after", {31'd0, in_ready},  32'd1);
        check("mr_no_stale",       {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        check("mr_no_stale_pop", {31'd0, out_valid}, 32'd0);
        check("mr_level_zero",   {30'd0, level},     32'd0);
        drive(1'b1, 3'd1, 16'h0055);
        step();
        drive(1'b0, 3'd0, 16'h0000);
        check("mr_fresh_data", out_data, 32'h00000055);
        step();
        check("mr_final_level", {30'd0, level}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
